// File: rtl/xnor_stream_decoder.sv
// xnor_stream_decoder
// Recovers plaintext from a frame of XNOR-encoded words by XNOR-ing each word
// with a per-frame Galois LFSR key stream, and buffers results in a 2-entry FIFO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, seed, len      frame request (sampled in IDLE only), initial key, word count
//   in_valid/in_ready     encoded word stream handshake, in_data carries the word
//   out_valid/out_ready   decoded word stream handshake, out_data/out_last from FIFO head
//   busy                  frame in progress (RUN or DRAIN)
//   done                  one-cycle pulse once a frame has fully left the block
module xnor_stream_decoder #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  state_t           state;
  logic [WIDTH-1:0] key;
  logic [WIDTH-1:0] key_next;
  logic [WIDTH-1:0] plain;
  logic [7:0]       remaining;

  entry_t           mem [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;

  // Handshakes and datapath; in_ready depends on registered state only.
  assign in_ready  = (state == RUN) && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr].data;
  assign out_last  = mem[rd_ptr].last;
  assign plain     = ~(in_data ^ key);
  assign key_next  = (key >> 1) ^ (key[0] ? TAPS : '0);

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Frame control: key stream, word countdown, busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= WIDTH'(1);
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Zero seed would lock the LFSR at zero.
            key       <= (seed == '0) ? WIDTH'(1) : seed;
            remaining <= len;
            if (len != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push) begin
            key       <= key_next;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (count_next == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // 2-entry output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{last: (remaining == 8'd1), data: plain};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_xnor_stream_decoder.sv
// Scoreboard bench for xnor_stream_decoder: the driver pushes expected decoded
// words as inputs are accepted; a negedge monitor pops and compares on each
// output handshake.
module tb_xnor_stream_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] seed;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  xnor_stream_decoder #(.WIDTH(16), .TAPS(16'hB400)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   negc = 0;
  int   last_pop_neg = -1;
  int   done_neg = -1;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clk) begin
    negc++;
    if (done) begin
      done_cnt++;
      done_neg = negc;
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e.d));
        chk("out_last", 32'(out_last), 32'(mon_e.l));
        if (out_last) last_pop_neg = negc;
      end
    end
  end

  task automatic do_start(input logic [15:0] s, input logic [7:0] l);
    @(posedge clk); #1;
    start = 1'b1; seed = s; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] exp_d, input logic exp_l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: got in_ready=0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back('{d: exp_d, l: exp_l});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      t++;
      if (t > 200) begin
        n_cmp++; n_err++;
        $display("FAIL %s_done_timeout: got done=0 expected 1", name);
        return;
      end
    end
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  logic [15:0] bp_exp [4];

  initial begin
    int acc;
    int base;
    int t;
    rst_n = 1'b0; start = 1'b0; seed = '0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("reset_outputs", 32'({in_ready, out_valid, out_data, out_last, busy, done}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic frame
    out_ready = 1'b1;
    base = done_cnt;
    do_start(16'hACE1, 8'd2);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    send(16'h0000, 16'h531E, 1'b0);
    send(16'hFFFF, 16'hE270, 1'b1);
    wait_done("basic");
    chk("basic_done_latency", 32'(done_neg), 32'(last_pop_neg + 1));
    chk("basic_done_count", 32'(done_cnt - base), 32'd1);

    // Zero seed
    do_start(16'h0000, 8'd1);
    send(16'h0000, 16'hFFFE, 1'b1);
    wait_done("zero_seed");

    // Backpressure: keys ACE1, E270, 7138, 389C
    bp_exp[0] = 16'h531E; bp_exp[1] = 16'h1D8F;
    bp_exp[2] = 16'h8EC7; bp_exp[3] = 16'hC763;
    out_ready = 1'b0;
    do_start(16'hACE1, 8'd4);
    in_valid = 1'b1; in_data = 16'h0000;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{d: bp_exp[acc], l: (acc == 3)});
        acc++;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    t = 0;
    while (acc < 4 && t < 100) begin
      @(negedge clk);
      t++;
      if (in_ready) begin
        exp_q.push_back('{d: bp_exp[acc], l: (acc == 3)});
        acc++;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    chk("bp_accepted_total", 32'(acc), 32'd4);
    wait_done("bp");
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero length
    do_start(16'h5555, 8'd0);
    chk("zlen_done", 32'(done), 32'd1);
    chk("zlen_busy", 32'(busy), 32'd0);
    chk("zlen_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("zlen_done_pulse", 32'(done), 32'd0);

    // Reset mid-frame
    out_ready = 1'b0;
    do_start(16'hACE1, 8'd3);
    send(16'h0000, 16'h531E, 1'b0);
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({in_ready, out_valid, out_data, out_last, busy, done}), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    do_start(16'hACE1, 8'd1);
    send(16'h0000, 16'h531E, 1'b1);
    wait_done("rst_restart");

    // Start ignored while busy: keys 1234, 091A, 048D
    do_start(16'h1234, 8'd3);
    send(16'h0000, 16'hEDCB, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; seed = 16'hFFFF; len = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    send(16'h0000, 16'hF6E5, 1'b0);
    send(16'h0000, 16'hFB72, 1'b1);
    wait_done("ign");

    repeat (4) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_done_count", 32'(done_cnt), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
